uart_tx: RTL and testbench

UART transmitter. It accepts 9-bit data words from the system-clock (clk) domain into an 8-entry async FIFO, then serializes each word on tx_o in the bit-clock (tck) domain. Each tck period is one bit time. Frame format per word: start bit, 5..9 data bits LSB first, optional parity bit, 1 or 2 stop bits. Flow control uses cts_n_i. The block is the transmit half of the UART IP, paired with the receiver on the same Config_t.

---
 rtl/uart_tx_pkg.sv | 57 +++++
 rtl/uart_tx_fifo_async.sv | 78 +++++++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART transmit types: configuration, status, FSM states and frame helpers.
// The receiver uses the same Config_t and parity convention.
package uart_tx_pkg;

  localparam int DATA_W = 9;

  typedef struct packed {
    logic       en_tx;
    logic [3:0] frame_len;
    logic       parity;
    logic       dstop;
    logic       flush_tx;
  } Config_t;

  typedef struct packed {
    logic frame_done;
    logic busy;
    logic fifo_full;
    logic fifo_empty;
  } TXStatus_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    D1     = 4'd2,
    D2     = 4'd3,
    D3     = 4'd4,
    D4     = 4'd5,
    D5     = 4'd6,
    D6     = 4'd7,
    D7     = 4'd8,
    D8     = 4'd9,
    D9     = 4'd10,
    PARITY = 4'd11,
    STOP   = 4'd12,
    DSTOP  = 4'd13
  } TxState_t;

  // Lowest set bit of frame_len wins; all-zero selects the 9-bit frame.
  function automatic logic [3:0] dataBits(input logic [3:0] frameLen);
    if (frameLen[0])      return 4'd5;
    else if (frameLen[1]) return 4'd6;
    else if (frameLen[2]) return 4'd7;
    else if (frameLen[3]) return 4'd8;
    else                  return 4'd9;
  endfunction

  function automatic logic parityOf(input logic [DATA_W-1:0] word, input logic [3:0] nBits);
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(nBits)) acc ^= word[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_async.sv
// Dual-clock FIFO with Gray-coded pointers and 2-flop pointer synchronizers.
// Flush is a read-side operation: the read pointer jumps to the synchronized write pointer.
module fifo_async #(
  parameter int DATA_SIZE   = 9,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 enq_clk_i,
  input  logic                 deq_clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_SIZE-1:0] enq_data_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  output logic [DATA_SIZE-1:0] deq_data_o,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  input  logic                 flush_i
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;

  logic [DATA_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [PW-1:0] wbin_q, wgray_q, rbin_q, rgray_q;
  logic [PW-1:0] rgraySync1_q, rgraySync2_q, wgraySync1_q, wgraySync2_q;
  logic [PW-1:0] wbin_d, rbin_d, wbinSync;
  logic push, pop, acc;

  assign enq_ready_o = (wgray_q != {~rgraySync2_q[PW-1:PW-2], rgraySync2_q[PW-3:0]});
  assign push        = enq_valid_i & enq_ready_o;
  assign wbin_d      = push ? wbin_q + PW'(1) : wbin_q;

  always_ff @(posedge enq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      rgraySync1_q <= '0;
      rgraySync2_q <= '0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wbin_d ^ (wbin_d >> 1);
      rgraySync1_q <= rgray_q;
      rgraySync2_q <= rgraySync1_q;
    end
  end

  always_ff @(posedge enq_clk_i) begin
    if (push) mem_q[wbin_q[AW-1:0]] <= enq_data_i;
  end

  always_comb begin
    wbinSync = '0;
    acc      = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc         = acc ^ wgraySync2_q[i];
      wbinSync[i] = acc;
    end
  end

  assign deq_valid_o = (rgray_q != wgraySync2_q);
  assign deq_data_o  = mem_q[rbin_q[AW-1:0]];
  assign pop         = deq_ready_i & deq_valid_o;
  assign rbin_d      = flush_i ? wbinSync : (pop ? rbin_q + PW'(1) : rbin_q);

  always_ff @(posedge deq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      wgraySync1_q <= '0;
      wgraySync2_q <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rbin_d ^ (rbin_d >> 1);
      wgraySync1_q <= wgray_q;
      wgraySync2_q <= wgraySync1_q;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: words enter an async FIFO on clk and are serialized on tck,
// one FSM state per bit time, with back-to-back frames when the next word is ready.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck,
  input  logic [DATA_W-1:0] tx_d_i,
  input  logic              tx_d_valid_i,
  output logic              tx_d_ready_o,
  input  logic              cts_n_i,
  output logic              tx_o,
  output logic              busy_o,
  output TXStatus_t         tx_status_o,
  input  Config_t           uart_config_i
);

  logic [DATA_W-1:0] deqData, shift_q;
  logic              deqValid, launch, lastStop, pop;
  logic [1:0]        ctsSync_q;
  TxState_t          state_q;
  logic [3:0]        nBits_q, bitIdx, launchBits;
  logic              parity_q, parEn_q, dstop_q, tx_q, busy_q, done_q;

  fifo_async #(
    .DATA_SIZE  (DATA_W),
    .BUFFER_SIZE(FIFO_DEPTH)
  ) txFifo (
    .enq_clk_i  (clk),
    .deq_clk_i  (tck),
    .rst_ni     (rst_n),
    .enq_data_i (tx_d_i),
    .enq_valid_i(tx_d_valid_i),
    .enq_ready_o(tx_d_ready_o),
    .deq_data_o (deqData),
    .deq_valid_o(deqValid),
    .deq_ready_i(pop),
    .flush_i    (uart_config_i.flush_tx)
  );

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) ctsSync_q <= 2'b11;
    else        ctsSync_q <= {ctsSync_q[0], cts_n_i};
  end

  // A word may only be popped from IDLE or from the final stop bit of a frame.
  assign launch     = uart_config_i.en_tx & ~ctsSync_q[1] & deqValid;
  assign lastStop   = ((state_q == STOP) & ~dstop_q) | (state_q == DSTOP);
  assign pop        = launch & ((state_q == IDLE) | lastStop);
  assign launchBits = dataBits(uart_config_i.frame_len);
  assign bitIdx     = state_q - D1;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      nBits_q  <= 4'd8;
      parity_q <= 1'b0;
      parEn_q  <= 1'b0;
      dstop_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        state_q  <= START;
        shift_q  <= deqData;
        nBits_q  <= launchBits;
        parity_q <= parityOf(deqData, launchBits);
        parEn_q  <= uart_config_i.parity;
        dstop_q  <= uart_config_i.dstop;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          START: begin
            state_q <= D1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            done_q  <= ~dstop_q;
          end
          STOP: begin
            if (dstop_q) begin
              state_q <= DSTOP;
              tx_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          DSTOP: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            if ((bitIdx + 4'd1) < nBits_q) begin
              state_q <= TxState_t'(state_q + 4'd1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end else if (parEn_q) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
              done_q  <= ~dstop_q;
            end
          end
        endcase
      end
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign tx_status_o = '{frame_done: done_q, busy: busy_q,
                         fifo_full: ~tx_d_ready_o, fifo_empty: ~deqValid};

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues the expected serial bits per frame,
// and a tck-side monitor pops and compares them whenever the transmitter is busy.
module tb_uart_tx;
  import uart_tx_pkg::*;

  typedef struct {
    logic bitVal;
    logic done;
  } ExpBit_t;

  logic      clk = 1'b0;
  logic      tck = 1'b0;
  logic      rst_n = 1'b0;
  logic [8:0] txData = '0;
  logic      txValid = 1'b0;
  logic      txReady;
  logic      ctsN = 1'b1;
  logic      txLine;
  logic      busy;
  TXStatus_t status;
  Config_t   cfg;

  ExpBit_t expQ[$];
  int      testsRun = 0;
  int      testsFailed = 0;
  bit      monEnable = 1'b0;
  bit      expectNoGap = 1'b0;
  logic    prevDone = 1'b0;

  always #5 clk = ~clk;
  always #20 tck = ~tck;

  uart_tx #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tck          (tck),
    .tx_d_i       (txData),
    .tx_d_valid_i (txValid),
    .tx_d_ready_o (txReady),
    .cts_n_i      (ctsN),
    .tx_o         (txLine),
    .busy_o       (busy),
    .tx_status_o  (status),
    .uart_config_i(cfg)
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Bits are listed in line order, leftmost bit first on the wire.
  task automatic pushFrame(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) expQ.push_back('{bitVal: bits[i], done: (i == 0)});
  endtask

  // Caller is aligned to a clk negedge; consecutive calls enqueue on consecutive cycles.
  task automatic applyStimulus(input logic [8:0] word);
    txData  = word;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  task automatic setConfig(input logic [3:0] len, input logic par, input logic dstop);
    @(negedge tck);
    cfg.frame_len = len;
    cfg.parity    = par;
    cfg.dstop     = dstop;
  endtask

  task automatic waitDrain(input int maxCycles, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge tck);
      n++;
    end
    checkOutput(name, expQ.size() == 0, 1'b1);
    expQ.delete();
    repeat (2) @(negedge tck);
  endtask

  task automatic waitBusy(input int maxCycles, input string name);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < maxCycles) begin
      @(negedge tck);
      n++;
      seen = busy;
    end
    checkOutput(name, seen, 1'b1);
  endtask

  always @(negedge tck) begin : monitor
    ExpBit_t e;
    if (monEnable) begin
      if (expectNoGap && prevDone && expQ.size() != 0) checkOutput("gap", busy, 1'b1);
      if (busy) begin
        if (expQ.size() == 0) begin
          checkOutput("extraBusy", busy, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("txBit", txLine, e.bitVal);
          checkOutput("frameDone", status.frame_done, e.done);
        end
      end else begin
        checkOutput("idleTx", txLine, 1'b1);
        checkOutput("idleDone", status.frame_done, 1'b0);
      end
      prevDone = status.frame_done;
    end else begin
      prevDone = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg = '{en_tx: 1'b1, frame_len: 4'b1000, parity: 1'b0, dstop: 1'b0, flush_tx: 1'b0};
    #33;
    checkOutput("rstTx", txLine, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", status.frame_done, 1'b0);
    checkOutput("rstEmpty", status.fifo_empty, 1'b1);
    checkOutput("rstReady", txReady, 1'b1);
    #4 rst_n = 1'b1;
    ctsN      = 1'b0;
    monEnable = 1'b1;
    repeat (3) @(negedge tck);

    // 8N1, 0xA5
    pushFrame(16'b0101001011, 10);
    @(negedge clk); applyStimulus(9'h0A5);
    waitDrain(40, "drain8N1");

    // 8 bits, parity, two stop bits
    setConfig(4'b1000, 1'b1, 1'b1);
    pushFrame(16'b010100101111, 12);
    @(negedge clk); applyStimulus(9'h0A5);
    waitDrain(40, "drain8P2");

    // 5 bits with parity; upper word bits must not leak into data or parity
    setConfig(4'b0001, 1'b1, 1'b0);
    pushFrame(16'b01111101, 8);
    @(negedge clk); applyStimulus(9'h0FF);
    waitDrain(40, "drain5P1");

    // 6 bits: lowest set frame_len bit wins
    setConfig(4'b0110, 1'b0, 1'b0);
    pushFrame(16'b00101011, 8);
    @(negedge clk); applyStimulus(9'h1EA);
    waitDrain(40, "drain6N1");

    // 9 bits, no parity
    setConfig(4'b0000, 1'b0, 1'b0);
    pushFrame(16'b01111111111, 11);
    @(negedge clk); applyStimulus(9'h1FF);
    waitDrain(40, "drain9N1");

    // back-to-back frames
    setConfig(4'b1000, 1'b0, 1'b0);
    expectNoGap = 1'b1;
    pushFrame(16'b0100000001, 10);
    pushFrame(16'b0000000011, 10);
    @(negedge clk); applyStimulus(9'h001); applyStimulus(9'h080);
    waitDrain(60, "drainB2B");
    expectNoGap = 1'b0;

    // fill with transmit disabled; 9th write must be dropped
    @(negedge tck); cfg.en_tx = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("ready%0d", i), txReady, (i < 8));
      applyStimulus((i < 8) ? 9'h055 : 9'h00F);
    end
    checkOutput("statusFull", status.fifo_full, 1'b1);
    for (int i = 0; i < 8; i++) pushFrame(16'b0101010101, 10);
    expectNoGap = 1'b1;
    @(negedge tck); cfg.en_tx = 1'b1;
    waitDrain(150, "drainFull");
    expectNoGap = 1'b0;
    repeat (4) @(negedge tck);
    checkOutput("fullDrainedEmpty", status.fifo_empty, 1'b1);

    // clear-to-send dropped during D3 holds the second word
    pushFrame(16'b0111100001, 10);
    pushFrame(16'b0000011111, 10);
    @(negedge clk); applyStimulus(9'h00F); applyStimulus(9'h0F0);
    waitBusy(10, "ctsStart");
    repeat (3) @(negedge tck);
    ctsN = 1'b1;
    for (int n = 0; n < 20 && expQ.size() > 10; n++) @(negedge tck);
    checkOutput("ctsFrame1Done", expQ.size() == 10, 1'b1);
    repeat (6) @(negedge tck);
    checkOutput("ctsHoldBusy", busy, 1'b0);
    checkOutput("ctsHoldFifo", status.fifo_empty, 1'b0);
    #1 ctsN = 1'b0;
    waitBusy(3, "ctsResume");
    waitDrain(30, "drainCts");

    // asynchronous reset during D4
    pushFrame(16'b0101001011, 10);
    @(negedge clk); applyStimulus(9'h0A5);
    waitBusy(10, "rstFrameStart");
    repeat (4) @(negedge tck);
    monEnable = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    checkOutput("midRstTx", txLine, 1'b1);
    checkOutput("midRstBusy", busy, 1'b0);
    expQ.delete();
    #50 rst_n = 1'b1;
    @(negedge tck);
    monEnable = 1'b1;
    repeat (10) @(negedge tck);
    checkOutput("rstNoFrame", busy, 1'b0);
    pushFrame(16'b0110000111, 10);
    @(negedge clk); applyStimulus(9'h0C3);
    waitDrain(40, "drainAfterRst");

    // flush during a frame: current frame completes, queued words vanish
    pushFrame(16'b0001111001, 10);
    @(negedge clk); applyStimulus(9'h03C); applyStimulus(9'h011); applyStimulus(9'h022);
    waitBusy(10, "flushStart");
    repeat (2) @(negedge tck);
    cfg.flush_tx = 1'b1;
    @(negedge tck);
    cfg.flush_tx = 1'b0;
    waitDrain(30, "drainFlush");
    repeat (3) @(negedge tck);
    checkOutput("flushEmpty", status.fifo_empty, 1'b1);
    checkOutput("flushReady", txReady, 1'b1);
    repeat (10) @(negedge tck);
    checkOutput("flushIdle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
